pll_phase_ctrl: RTL and testbench

PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

---
 rtl/pll_ctrl_pkg.sv | 17 +
 rtl/sync2.sv | 21 ++
 rtl/pll_phase_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared state encoding and PHASEDIR values for the PLL phase controller
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      RST_PLL   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      IDLE      = 3'd3,
      SETUP     = 3'd4,
      STEP_LO   = 3'd5,
      STEP_HI   = 3'd6
   } pll_state_t;

   localparam logic DIR_LAG  = 1'b0;
   localparam logic DIR_LEAD = 1'b1;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous level
module sync2 (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_phase_ctrl.sv
// rtl/pll_phase_ctrl.sv - PLL reset/lock sequencing and dynamic phase-step command engine
module pll_phase_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int RST_CYCLES         = 16,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STEP_LOW_CYCLES    = 4,
   parameter int STEP_GAP_CYCLES    = 4
) (
   input  logic       clock_in,
   input  logic       reset_n,
   input  logic       locked,
   output logic       pll_rst,
   output logic [1:0] phasesel,
   output logic       phasedir,
   output logic       phasestep,
   output logic       phaseloadreg,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_sel,
   input  logic       cmd_dir,
   input  logic [3:0] cmd_count,
   output logic       busy,
   output logic       done,
   output logic       ready,
   output logic       user_rst_n,
   output logic       lock_lost,
   input  logic       lock_lost_clr
);

   localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
   localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES);
   localparam logic [15:0] LO_LAST     = 16'(STEP_LOW_CYCLES - 1);
   localparam logic [15:0] HI_LAST     = 16'(STEP_GAP_CYCLES - 1);

   logic        lk;
   pll_state_t  state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [15:0] left, left_nxt, left_dec;
   logic [1:0]  sel_q, sel_nxt;
   logic        dir_q, dir_nxt;
   logic        done_q, done_nxt;
   logic        lost_set;
   logic        user_rst_q;
   logic        ready_i;
   logic        xfer;

   sync2 u_lock_sync (
      .clk    (clock_in),
      .resetn (reset_n),
      .d      (locked),
      .q      (lk)
   );

   assign ready_i  = (state == IDLE) || (state == SETUP) || (state == STEP_LO) || (state == STEP_HI);
   assign xfer     = (state == IDLE) && cmd_valid;
   assign left_dec = left - 16'd1;

   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         state      <= RST_PLL;
         cnt        <= 16'd0;
         left       <= 16'd0;
         sel_q      <= 2'd0;
         dir_q      <= DIR_LAG;
         done_q     <= 1'b0;
         user_rst_q <= 1'b0;
         lock_lost  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         left       <= left_nxt;
         sel_q      <= sel_nxt;
         dir_q      <= dir_nxt;
         done_q     <= done_nxt;
         user_rst_q <= ready_i;
         if (lost_set)
            lock_lost <= 1'b1;
         else if (lock_lost_clr)
            lock_lost <= 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      left_nxt  = left;
      sel_nxt   = sel_q;
      dir_nxt   = dir_q;
      done_nxt  = 1'b0;
      lost_set  = 1'b0;
      case (state)
         RST_PLL: begin
            if (cnt == RST_LAST) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = 16'd0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         WAIT_LOCK: begin
            if (lk) begin
               state_nxt = STABLE;
               cnt_nxt   = 16'd0;
            end
         end
         STABLE: begin
            if (!lk) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = 16'd0;
            end else if (cnt == STABLE_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = 16'd0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         IDLE: begin
            if (xfer) begin
               sel_nxt  = cmd_sel;
               dir_nxt  = cmd_dir;
               left_nxt = {12'd0, cmd_count};
               cnt_nxt  = 16'd0;
               if (cmd_count == 4'd0)
                  done_nxt = 1'b1;
               else
                  state_nxt = SETUP;
            end
         end
         SETUP: begin
            state_nxt = STEP_LO;
            cnt_nxt   = 16'd0;
         end
         STEP_LO: begin
            if (cnt == LO_LAST) begin
               state_nxt = STEP_HI;
               cnt_nxt   = 16'd0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         STEP_HI: begin
            if (cnt == HI_LAST) begin
               cnt_nxt  = 16'd0;
               left_nxt = left_dec;
               if (left_dec == 16'd0) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = STEP_LO;
               end
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         default: begin
            state_nxt = RST_PLL;
            cnt_nxt   = 16'd0;
         end
      endcase
      // Lock loss overrides everything: abort the command and restart the PLL.
      if (ready_i && !lk) begin
         state_nxt = RST_PLL;
         cnt_nxt   = 16'd0;
         left_nxt  = 16'd0;
         sel_nxt   = sel_q;
         dir_nxt   = dir_q;
         done_nxt  = 1'b0;
         lost_set  = 1'b1;
      end
   end

   assign pll_rst      = (state == RST_PLL);
   assign phasestep    = (state != STEP_LO);
   assign phaseloadreg = 1'b1;
   assign phasesel     = sel_q;
   assign phasedir     = dir_q;
   assign cmd_ready    = (state == IDLE);
   assign busy         = (state == SETUP) || (state == STEP_LO) || (state == STEP_HI);
   assign done         = done_q;
   assign ready        = ready_i;
   assign user_rst_n   = user_rst_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb/tb_pll_phase_ctrl.sv - directed self-checking bench for pll_phase_ctrl
module tb_pll_phase_ctrl;
   import pll_ctrl_pkg::*;

   logic       clk;
   logic       reset_n;
   logic       locked;
   logic       pll_rst;
   logic [1:0] phasesel;
   logic       phasedir;
   logic       phasestep;
   logic       phaseloadreg;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_sel;
   logic       cmd_dir;
   logic [3:0] cmd_count;
   logic       busy;
   logic       done;
   logic       ready;
   logic       user_rst_n;
   logic       lock_lost;
   logic       lock_lost_clr;

   int n_cmp = 0;
   int n_err = 0;

   pll_phase_ctrl dut (
      .clock_in      (clk),
      .reset_n       (reset_n),
      .locked        (locked),
      .pll_rst       (pll_rst),
      .phasesel      (phasesel),
      .phasedir      (phasedir),
      .phasestep     (phasestep),
      .phaseloadreg  (phaseloadreg),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_sel       (cmd_sel),
      .cmd_dir       (cmd_dir),
      .cmd_count     (cmd_count),
      .busy          (busy),
      .done          (done),
      .ready         (ready),
      .user_rst_n    (user_rst_n),
      .lock_lost     (lock_lost),
      .lock_lost_clr (lock_lost_clr)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] out_vec();
      return {pll_rst, phasestep, phaseloadreg, phasesel, phasedir,
              cmd_ready, busy, done, ready, user_rst_n, lock_lost};
   endfunction

   // Starts on a cycle where pll_rst is high and n0 RST_PLL cycles already elapsed.
   task automatic measure_relock(input string tag, input int n0);
      int n;
      int m;
      n = n0;
      while (pll_rst && n < 100) begin
         n++;
         tick();
      end
      chk({tag, "_rst_len"}, n, 16);
      m = 0;
      while (!ready && m < 3000) begin
         m++;
         tick();
      end
      chk({tag, "_lock_wait"}, m, 1026);
      chk({tag, "_urst_lag"}, user_rst_n, 1'b0);
      tick();
      chk({tag, "_urst_up"}, user_rst_n, 1'b1);
   endtask

   initial begin
      logic [31:0] trace;
      int          busy_n;
      int          done_n;
      int          sel_bad;
      int          k;
      logic        seen_done;

      reset_n       = 1'b0;
      locked        = 1'b1;
      cmd_valid     = 1'b0;
      cmd_sel       = 2'd0;
      cmd_dir       = 1'b0;
      cmd_count     = 4'd0;
      lock_lost_clr = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", out_vec(), 12'hE00);

      reset_n = 1'b1;
      measure_relock("boot", 0);
      chk("idle_cmd_ready", cmd_ready, 1'b1);
      chk("idle_busy", busy, 1'b0);

      // Three lead steps on output 2.
      cmd_valid = 1'b1; cmd_sel = 2'd2; cmd_dir = DIR_LEAD; cmd_count = 4'd3;
      tick();
      cmd_valid = 1'b0;
      chk("setup_sel_dir", {phasesel, phasedir, cmd_ready}, 4'b1010);
      trace = 0; busy_n = 0; done_n = 0; sel_bad = 0;
      while (busy && busy_n < 100) begin
         busy_n++;
         trace = {trace[30:0], phasestep};
         if (done) done_n++;
         if (phasesel != 2'd2 || phasedir != 1'b1) sel_bad++;
         tick();
      end
      chk("busy_len", busy_n, 25);
      chk("step_trace", trace, 32'h010F0F0F);
      chk("sel_stable", sel_bad, 0);
      chk("no_early_done", done_n, 0);
      chk("done_at_idle", {done, cmd_ready}, 2'b11);
      tick();
      chk("done_single", done, 1'b0);

      // Zero-count command completes without stepping.
      cmd_valid = 1'b1; cmd_sel = 2'd1; cmd_dir = DIR_LAG; cmd_count = 4'd0;
      tick();
      cmd_valid = 1'b0;
      chk("zero_done", {done, busy, phasestep, phasesel}, 5'b10101);
      tick();
      chk("zero_done_end", {done, phasestep}, 2'b01);

      // Lock drops in the middle of the second step.
      cmd_valid = 1'b1; cmd_sel = 2'd0; cmd_dir = DIR_LAG; cmd_count = 4'd3;
      tick();
      cmd_valid = 1'b0;
      repeat (10) tick();
      chk("step2_low", phasestep, 1'b0);
      locked = 1'b0;
      k = 0; seen_done = 1'b0;
      while (!pll_rst && k < 10) begin
         tick();
         k++;
         if (done) seen_done = 1'b1;
      end
      chk("abort_latency", k, 3);
      chk("abort_state", {phasestep, ready, busy, done, lock_lost}, 5'b10001);
      chk("abort_no_done", seen_done, 1'b0);
      locked = 1'b1;
      tick();
      chk("abort_urst", user_rst_n, 1'b0);
      measure_relock("relock", 1);

      // Clear alone, then clear colliding with a new loss.
      lock_lost_clr = 1'b1;
      tick();
      lock_lost_clr = 1'b0;
      chk("clr_alone", lock_lost, 1'b0);
      locked = 1'b0;
      lock_lost_clr = 1'b1;
      repeat (3) tick();
      lock_lost_clr = 1'b0;
      chk("set_wins", {pll_rst, lock_lost}, 2'b11);
      tick();
      chk("set_sticky", lock_lost, 1'b1);
      locked = 1'b1;
      lock_lost_clr = 1'b1;
      tick();
      lock_lost_clr = 1'b0;
      chk("clr_after_set", lock_lost, 1'b0);
      k = 0;
      while (!ready && k < 3000) begin
         tick();
         k++;
      end
      chk("ready_again", ready, 1'b1);

      // Reset in the middle of a step.
      cmd_valid = 1'b1; cmd_sel = 2'd3; cmd_dir = DIR_LEAD; cmd_count = 4'd2;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("pre_reset_low", {phasestep, busy}, 2'b01);
      reset_n = 1'b0;
      tick();
      chk("mid_reset_outputs", out_vec(), 12'hE00);
      tick();
      chk("mid_reset_hold", out_vec(), 12'hE00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
